// File: rtl/axis_rx_fifo_arb.sv
`default_nettype none
// ============================================================================
//  Module   : axis_rx_fifo_arb
//  Purpose  : Two-channel RX packet scheduler. Shares one AXIS master port
//             between two RX bridge FIFO pairs (64-bit data FIFO + 32-bit
//             byte-count FIFO). The arbiter works round-robin at packet
//             boundaries. It reads the packet's byte count, streams
//             ceil(bytes/8) data words, and generates tstrb/tlast.
//  Ports    : rx_mac_aclk/reset        - clock, sync active-high reset
//             rdempty_rf*/rdempty_rcf* - data / count FIFO empty flags
//             dataout_rf*/dataout_rcf* - FIFO outputs (1-cycle read latency)
//             rden_rf*/rden_rcf*       - FIFO read enables
//             rx_axis_mac_*            - AXIS master (tdata/tvalid/tlast/
//                                        tstrb out, tready in)
//             grant_ch, busy, pkt_done, len_err - status
//  Revision : 1.0  initial release
// ============================================================================
module axis_rx_fifo_arb #(
  parameter int          DATA_WIDTH = 64,
  parameter int          BCNT_WIDTH = 32,
  parameter logic [15:0] MAX_BYTES  = 16'd9600
) (
  input  logic                  rx_mac_aclk,
  input  logic                  reset,
  input  logic                  rdempty_rf0,
  input  logic                  rdempty_rf1,
  input  logic                  rdempty_rcf0,
  input  logic                  rdempty_rcf1,
  input  logic [DATA_WIDTH-1:0] dataout_rf0,
  input  logic [DATA_WIDTH-1:0] dataout_rf1,
  input  logic [BCNT_WIDTH-1:0] dataout_rcf0,
  input  logic [BCNT_WIDTH-1:0] dataout_rcf1,
  output logic                  rden_rf0,
  output logic                  rden_rf1,
  output logic                  rden_rcf0,
  output logic                  rden_rcf1,
  output logic [DATA_WIDTH-1:0] rx_axis_mac_tdata,
  output logic                  rx_axis_mac_tvalid,
  output logic                  rx_axis_mac_tlast,
  output logic [7:0]            rx_axis_mac_tstrb,
  input  logic                  rx_axis_mac_tready,
  output logic                  grant_ch,
  output logic                  busy,
  output logic                  pkt_done,
  output logic                  len_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RDCNT = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  // Output buffer entry: {last, strb[7:0], data}
  localparam int ENTRY_W = DATA_WIDTH + 9;

  logic [2:0]         r_state;
  logic               r_grant;
  logic               r_last_grant;
  logic [13:0]        r_words_left;
  logic [7:0]         r_last_strb;
  logic               r_rd_vld;      // read issued last cycle, data arrives now
  logic               r_rd_last;
  logic [7:0]         r_rd_strb;
  logic [ENTRY_W-1:0] r_buf [0:2];
  logic [1:0]         r_wptr;
  logic [1:0]         r_rptr;
  logic [1:0]         r_occ;

  logic               w_elig0;
  logic               w_elig1;
  logic               w_winner;
  logic [15:0]        w_bytes;
  logic [16:0]        w_bytes_rnd;
  logic               w_len_bad;
  logic [7:0]         w_last_strb;
  logic               w_rf_empty_g;
  logic               w_room;
  logic               w_issue;
  logic               w_tvalid;
  logic               w_pop;
  logic [ENTRY_W-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic               w_unused_cnt_lo;

  function automatic logic [1:0] f_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_elig0 = !rdempty_rcf0 && !rdempty_rf0;
  assign w_elig1 = !rdempty_rcf1 && !rdempty_rf1;
  // On a tie the channel that did not win last time goes next.
  assign w_winner = (w_elig0 && w_elig1) ? !r_last_grant : w_elig1;

  assign w_bytes     = r_grant ? dataout_rcf1[BCNT_WIDTH-1 -: 16] : dataout_rcf0[BCNT_WIDTH-1 -: 16];
  assign w_bytes_rnd = {1'b0, w_bytes} + 17'd7;
  assign w_len_bad   = (w_bytes == 16'd0) || (w_bytes > MAX_BYTES);
  assign w_last_strb = (w_bytes[2:0] == 3'd0) ? 8'hFF : ((8'h01 << w_bytes[2:0]) - 8'h01);
  assign w_unused_cnt_lo = &{1'b0, dataout_rcf0[BCNT_WIDTH-17:0], dataout_rcf1[BCNT_WIDTH-17:0]};

  // Buffered words plus the one possibly in flight must fit in 3 entries,
  // so a stalled consumer can never overflow the buffer.
  assign w_rf_empty_g = r_grant ? rdempty_rf1 : rdempty_rf0;
  assign w_room       = ({1'b0, r_occ} + {2'b00, r_rd_vld}) < 3'd3;
  assign w_issue      = (r_state == S_DATA) && (r_words_left != 14'd0) && !w_rf_empty_g && w_room;

  assign w_rd_data = r_grant ? dataout_rf1 : dataout_rf0;
  assign w_tvalid  = (r_occ != 2'd0);
  assign w_pop     = w_tvalid && rx_axis_mac_tready;
  assign w_head    = r_buf[r_rptr];

  // Read enables are suppressed during reset so no FIFO entry is consumed
  // while the controller is being cleared.
  assign rden_rcf0 = !reset && (r_state == S_RDCNT) && !r_grant;
  assign rden_rcf1 = !reset && (r_state == S_RDCNT) &&  r_grant;
  assign rden_rf0  = !reset && w_issue && !r_grant;
  assign rden_rf1  = !reset && w_issue &&  r_grant;

  // Head is masked when empty so idle outputs read as zero.
  assign rx_axis_mac_tvalid = w_tvalid;
  assign rx_axis_mac_tdata  = w_tvalid ? w_head[DATA_WIDTH-1:0] : '0;
  assign rx_axis_mac_tstrb  = w_tvalid ? w_head[DATA_WIDTH +: 8] : 8'h00;
  assign rx_axis_mac_tlast  = w_tvalid && w_head[ENTRY_W-1];

  assign grant_ch = r_grant;
  assign busy     = (r_state != S_IDLE);
  assign pkt_done = (r_state == S_DRAIN) && w_pop && w_head[ENTRY_W-1];
  assign len_err  = (r_state == S_LATCH) && w_len_bad;

  // Buffer storage carries no reset; the occupancy count decides validity.
  always_ff @(posedge rx_mac_aclk) begin
    if (!reset && r_rd_vld) begin
      r_buf[r_wptr] <= {r_rd_last, r_rd_strb, w_rd_data};
    end
  end

  always_ff @(posedge rx_mac_aclk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_words_left <= 14'd0;
      r_last_strb  <= 8'h00;
      r_rd_vld     <= 1'b0;
      r_rd_last    <= 1'b0;
      r_rd_strb    <= 8'h00;
      r_wptr       <= 2'd0;
      r_rptr       <= 2'd0;
      r_occ        <= 2'd0;
    end else begin
      r_rd_vld <= w_issue;
      if (w_issue) begin
        r_rd_last <= (r_words_left == 14'd1);
        r_rd_strb <= (r_words_left == 14'd1) ? r_last_strb : 8'hFF;
      end
      if (r_rd_vld) r_wptr <= f_inc(r_wptr);
      if (w_pop)    r_rptr <= f_inc(r_rptr);
      r_occ <= r_occ + {1'b0, r_rd_vld} - {1'b0, w_pop};

      case (r_state)
        S_IDLE: begin
          if (w_elig0 || w_elig1) begin
            r_grant      <= w_winner;
            r_last_grant <= w_winner;
            r_state      <= S_RDCNT;
          end
        end
        S_RDCNT: r_state <= S_LATCH;
        S_LATCH: begin
          if (w_len_bad) begin
            r_state <= S_IDLE;
          end else begin
            r_words_left <= w_bytes_rnd[16:3];
            r_last_strb  <= w_last_strb;
            r_state      <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_issue) begin
            r_words_left <= r_words_left - 14'd1;
            if (r_words_left == 14'd1) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_pop && w_head[ENTRY_W-1]) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
